// File: rtl/aes_block_serializer_if.sv
// Handshake bundle between a block producer, the serializer and a word sink.
// Optional parity output is present only when AES_SER_PARITY_EN is defined.
interface aes_block_serializer_if #(
   parameter int WORD_W  = 32,
   parameter int N_WORDS = 4
);
   logic                        load_valid;
   logic                        load_ready;
   logic [WORD_W*N_WORDS-1:0]   block_in;
   logic                        out_valid;
   logic                        out_ready;
   logic [WORD_W-1:0]           out_word;
   logic                        out_last;
   logic                        busy;
`ifdef AES_SER_PARITY_EN
   logic                        out_parity;
`endif

   modport master (
      output load_valid,
      output block_in,
      output out_ready,
      input  load_ready,
      input  out_valid,
      input  out_word,
      input  out_last,
      input  busy
`ifdef AES_SER_PARITY_EN
      , input out_parity
`endif
   );

   modport slave (
      input  load_valid,
      input  block_in,
      input  out_ready,
      output load_ready,
      output out_valid,
      output out_word,
      output out_last,
      output busy
`ifdef AES_SER_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/aes_block_serializer.sv
// Wide AES block in, WORD_W-bit words out MSW first over valid/ready.
// Define AES_SER_PARITY_EN to add the out_parity output.
module aes_block_serializer #(
   parameter int WORD_W  = 32,
   parameter int N_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   aes_block_serializer_if.slave bus
);
   localparam int BW = WORD_W * N_WORDS;
   localparam int CW = $clog2(N_WORDS);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [BW-1:0]   r_shift;
   logic [CW-1:0]   r_cnt;
   logic            w_send;
   logic            w_last;
   logic            w_fire;
   logic            w_fire_last;
   logic            w_load_ready;
   logic            w_load;
   logic [WORD_W-1:0] w_word;

   assign w_send       = (r_state == SEND);
   assign w_last       = (r_cnt == CNT_LAST);
   assign w_fire       = w_send & bus.out_ready;
   assign w_fire_last  = w_fire & w_last;
   assign w_load_ready = ~w_send | w_fire_last;
   assign w_load       = bus.load_valid & w_load_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (bus.load_valid) w_next = SEND;
         SEND: if (w_fire_last && !bus.load_valid) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Counter holds at the last index when the block drains; only a load rewinds it.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_shift <= bus.block_in;
         r_cnt   <= '0;
      end else if (w_fire) begin
         r_shift <= {r_shift[BW-WORD_W-1:0], {WORD_W{1'b0}}};
         if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
   end

   assign w_word = w_send ? r_shift[BW-1 -: WORD_W] : '0;

   assign bus.load_ready = w_load_ready;
   assign bus.out_valid  = w_send;
   assign bus.out_word   = w_word;
   assign bus.out_last   = w_send & w_last;
   assign bus.busy       = w_send;

`ifdef AES_SER_PARITY_EN
   assign bus.out_parity = ^w_word;
`endif
endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Unloads a completed AES block (ciphertext or plaintext) from the wide cipher-state register.
- Streams the block out as fixed-width words over a valid/ready handshake.
- Sits between the round datapath's enable-loaded state register and the narrow output bus.
- Counterpart of the input word-to-block assembly path: wide parallel in, narrow serial out.

Parameters:
- WORD_W, 32, width of each output word in bits.
- N_WORDS, 4, words per block; block width is WORD_W*N_WORDS (128 by default); N_WORDS >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- load_valid  input  1  block_in holds a valid block to unload.
- load_ready  output  1  serializer can accept a block this cycle.
- block_in  input  WORD_W*N_WORDS  block to serialize; word 0 = bits [WORD_W*N_WORDS-1 -: WORD_W] (MSW).
- out_valid  output  1  out_word holds a valid word.
- out_ready  input  1  downstream accepts out_word this cycle.
- out_word  output  WORD_W  current word.
- out_last  output  1  current word is word N_WORDS-1.
- busy  output  1  block held or being sent (state SEND).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, nrst.
- Reset: state IDLE; shift register, word counter, out_word = 0; out_valid = 0, out_last = 0, busy = 0.
- Reset asserted mid-block aborts the block; there is no resume.
- States: IDLE, SEND.
- IDLE:
  - load_ready = 1.
  - On load_valid: capture block_in into the internal shift register and clear the word counter.
  - Next cycle: SEND, out_valid = 1, out_word = word 0.
  - Load-to-first-word latency: 1 cycle.
- SEND:
  - out_valid = 1.
  - out_word and out_last stay stable while out_ready = 0.
  - On out_ready: shift the register left by WORD_W (zero fill) and increment the counter.
  - out_last = 1 exactly when the counter = N_WORDS-1.
- Last word accepted (out_valid & out_ready & out_last):
  - With load_valid in the same cycle: load_ready = 1 and the new block is captured. Stay in SEND with word 0 of the new block next cycle; no bubble.
  - Otherwise: go to IDLE, out_valid = 0.
- load_ready = (state == IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready, and it is intended.
- load_valid in SEND before the last word is accepted: ignored, load_ready = 0, no capture.
- Counter width is $clog2(N_WORDS). The counter wraps to 0 only via a new load, never by overflow.
- busy = (state == SEND).
- out_word is driven from the register MSW. It is 0 in IDLE.

Optional Feature:
- Macro: AES_SER_PARITY_EN.
- Defined:
  - Adds port out_parity, output, 1 bit.
  - out_parity is the even parity (XOR reduction) of out_word, valid whenever out_valid = 1 and 0 in IDLE/reset.
  - Stable with out_word during stalls.
- Undefined: the port does not exist, and there is no parity logic.

Test Plan:
- Reset mid-block: nrst low during word 2 -> out_valid = 0, busy = 0, out_word = 0 immediately (async). After release, load_ready = 1 and the old block is never resumed.
- Basic unload: load 0x00112233_44556677_8899AABB_CCDDEEFF with out_ready = 1 -> 1 cycle later, 4 consecutive words 00112233, 44556677, 8899AABB, CCDDEEFF. out_last only on the 4th word, then IDLE.
- Backpressure: same block, out_ready low on cycles 2-4 of SEND -> word 44556677 held stable with out_valid = 1. Total accepted words = 4, in order, none duplicated.
- Back-to-back: second block 0xDEADBEEF_... presented with load_valid during last-word acceptance -> load_ready = 1, next cycle out_word = DEADBEEF, no idle cycle.
- Early load ignored: load_valid pulsed with a different block during word 1 -> load_ready = 0 and the remaining words still come from the original block.
- Parity (AES_SER_PARITY_EN):
  - out_word 00000001 -> out_parity = 1.
  - out_word 00000003 -> out_parity = 0.
  - Undefined build compiles without the out_parity port.
